alu_issue_ctrl: RTL and testbench

//  Drives the ALU: accepts one MIPS instruction plus register operands over a valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller between register read and writeback: decodes a MIPS instruction,
// drives the ALU for one or MULDIV_CYCLES cycles, then offers a single writeback/branch result.
module alu_issue_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  alu_opselect,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_res,
    input  logic        alu_v,
    input  logic        alu_zero,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        br_taken,
    output logic        exc_ovf,
    output logic        exc_illegal
);

    localparam int unsigned CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q, ovf_en_q, beq_q;

    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext, imm_zext, shamt_zext;
    logic [3:0]  d_op;
    logic [31:0] d_x, d_y;
    logic [4:0]  d_rd;
    logic        d_we, d_ovf_en, d_beq, d_muldiv, d_ill;

    // Branches use alu_res[0]; the zero flag and the rs field are not needed here.
    logic [5:0] unused_bits;
    assign unused_bits = {alu_zero, instr[25:21]};

    assign opcode     = instr[31:26];
    assign funct      = instr[5:0];
    assign imm_sext   = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext   = {16'h0000, instr[15:0]};
    assign shamt_zext = {27'd0, instr[10:6]};

    always_comb begin
        d_op     = 4'b0000;
        d_x      = rs_data;
        d_y      = rt_data;
        d_rd     = instr[20:16];
        d_we     = 1'b1;
        d_ovf_en = 1'b0;
        d_beq    = 1'b0;
        d_muldiv = 1'b0;
        d_ill    = 1'b0;
        unique case (opcode)
            6'h00: begin
                d_rd = instr[15:11];
                unique case (funct)
                    6'h20: begin d_op = 4'b0000; d_ovf_en = 1'b1; end
                    6'h22: begin d_op = 4'b0001; d_ovf_en = 1'b1; end
                    6'h18: begin d_op = 4'b0010; d_muldiv = 1'b1; end
                    6'h1A: begin d_op = 4'b0011; d_muldiv = 1'b1; end
                    6'h00: begin d_op = 4'b0100; d_x = rt_data; d_y = shamt_zext; end
                    6'h02: begin d_op = 4'b0101; d_x = rt_data; d_y = shamt_zext; end
                    6'h2A: d_op = 4'b0111;
                    6'h24: d_op = 4'b1001;
                    6'h25: d_op = 4'b1010;
                    6'h27: d_op = 4'b1100;
                    default: d_ill = 1'b1;
                endcase
            end
            6'h08: begin d_op = 4'b0000; d_y = imm_sext; d_ovf_en = 1'b1; end
            6'h0A: begin d_op = 4'b0111; d_y = imm_sext; end
            6'h0C: begin d_op = 4'b1001; d_y = imm_zext; end
            6'h0D: begin d_op = 4'b1010; d_y = imm_zext; end
            6'h04: begin d_op = 4'b1000; d_we = 1'b0; d_beq = 1'b1; end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_op     = 4'b0000;
            d_x      = '0;
            d_y      = '0;
            d_rd     = '0;
            d_we     = 1'b0;
            d_ovf_en = 1'b0;
            d_beq    = 1'b0;
            d_muldiv = 1'b0;
        end
        // r0 is hardwired, never write it
        if (d_rd == 5'd0) d_we = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            ovf_en_q     <= 1'b0;
            beq_q        <= 1'b0;
            instr_ready  <= 1'b1;
            alu_opselect <= 4'b0000;
            alu_x        <= '0;
            alu_y        <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            br_taken     <= 1'b0;
            exc_ovf      <= 1'b0;
            exc_illegal  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        alu_opselect <= d_op;
                        alu_x        <= d_x;
                        alu_y        <= d_y;
                        wb_rd        <= d_rd;
                        we_q         <= d_we;
                        ovf_en_q     <= d_ovf_en;
                        beq_q        <= d_beq;
                        cnt_q        <= d_muldiv ? CW'(MULDIV_CYCLES - 1) : '0;
                        instr_ready  <= 1'b0;
                        wb_we        <= 1'b0;
                        wb_data      <= '0;
                        br_taken     <= 1'b0;
                        exc_ovf      <= 1'b0;
                        exc_illegal  <= d_ill;
                        if (d_ill) begin
                            wb_valid <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q  <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        wb_data  <= alu_res;
                        wb_we    <= we_q & ~(ovf_en_q & alu_v);
                        exc_ovf  <= ovf_en_q & alu_v;
                        br_taken <= beq_q & alu_res[0];
                        wb_valid <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (wb_ready) begin
                        wb_valid    <= 1'b0;
                        instr_ready <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed instructions, a behavioural ALU model,
// and a negedge monitor comparing each accepted writeback against queued expectations.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic [3:0]  alu_opselect;
    logic [31:0] alu_x, alu_y, alu_res;
    logic        alu_v, alu_zero;
    logic        wb_valid, wb_ready = 1'b1, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        br_taken, exc_ovf, exc_illegal;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        br;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_opselect(alu_opselect), .alu_x(alu_x), .alu_y(alu_y),
        .alu_res(alu_res), .alu_v(alu_v), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .br_taken(br_taken), .exc_ovf(exc_ovf), .exc_illegal(exc_illegal)
    );

    // Behavioural ALU
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (alu_opselect)
            4'b0000: begin
                alu_res = alu_x + alu_y;
                alu_v   = (alu_x[31] == alu_y[31]) && (alu_res[31] != alu_x[31]);
            end
            4'b0001: begin
                alu_res = alu_x - alu_y;
                alu_v   = (alu_x[31] != alu_y[31]) && (alu_res[31] != alu_x[31]);
            end
            4'b0010: alu_res = alu_x * alu_y;
            4'b0011: alu_res = (alu_y == 0) ? 32'd0 : alu_x / alu_y;
            4'b0100: alu_res = alu_x << alu_y[4:0];
            4'b0101: alu_res = alu_x >> alu_y[4:0];
            4'b0111: alu_res = {31'd0, $signed(alu_x) < $signed(alu_y)};
            4'b1000: alu_res = {31'd0, alu_x == alu_y};
            4'b1001: alu_res = alu_x & alu_y;
            4'b1010: alu_res = alu_x | alu_y;
            4'b1100: alu_res = ~(alu_x | alu_y);
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whenever a writeback handshake is about to complete
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: got wb_data %h expected no result", wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                chk("br_taken", {31'd0, br_taken}, {31'd0, e.br});
                chk("exc_ovf", {31'd0, exc_ovf}, {31'd0, e.ovf});
                chk("exc_illegal", {31'd0, exc_illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic run(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [3:0] op, input logic [31:0] ex, input logic [31:0] ey,
                       input int lat, input exp_t e, input int stall);
        int n;
        @(negedge clk);
        chk("ready_before", {31'd0, instr_ready}, 32'd1);
        exp_q.push_back(e);
        if (stall > 0) wb_ready = 1'b0;
        instr = i; rs_data = rs; rt_data = rt; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (wb_valid) break;
            chk("exec_op", {28'd0, alu_opselect}, {28'd0, op});
            chk("exec_x", alu_x, ex);
            chk("exec_y", alu_y, ey);
            chk("exec_ready", {31'd0, instr_ready}, 32'd0);
            n++;
            if (n > 20) begin
                total++;
                bad++;
                $display("FAIL timeout: got no wb_valid after %0d cycles expected %0d", n, lat);
                break;
            end
        end
        chk("latency", n, lat);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, wb_valid}, 32'd1);
                chk("stall_data", wb_data, e.data);
                chk("stall_ready", {31'd0, instr_ready}, 32'd0);
            end
            @(posedge clk);
            #1 wb_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_op", {28'd0, alu_opselect}, 32'd0);
        chk("rst_x", alu_x, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_flags", {28'd0, wb_we, br_taken, exc_ovf, exc_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   instr         rs            rt            op       x             y           lat  {we rd data br ovf ill}
        run(32'h00221820, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,       2, '{1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h20240001, 32'h7FFFFFFF, 32'd0,        4'b0000, 32'h7FFFFFFF, 32'd1,       2, '{1'b0, 5'd4, 32'h80000000, 1'b0, 1'b1, 1'b0}, 0);
        run(32'h2004FFFF, 32'd0,        32'd0,        4'b0000, 32'd0,        32'hFFFFFFFF, 2, '{1'b1, 5'd4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00222022, 32'h80000000, 32'd1,        4'b0001, 32'h80000000, 32'd1,       2, '{1'b0, 5'd4, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}, 0);
        run(32'h00222818, 32'd6,        32'd7,        4'b0010, 32'd6,        32'd7,       5, '{1'b1, 5'd5, 32'd42, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h0022281A, 32'd43,       32'd5,        4'b0011, 32'd43,       32'd5,       5, '{1'b1, 5'd5, 32'd8, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h10220010, 32'd9,        32'd9,        4'b1000, 32'd9,        32'd9,       2, '{1'b0, 5'd2, 32'd1, 1'b1, 1'b0, 1'b0}, 0);
        run(32'h10220010, 32'd9,        32'd8,        4'b1000, 32'd9,        32'd8,       2, '{1'b0, 5'd2, 32'd0, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00051100, 32'd0,        32'd1,        4'b0100, 32'd1,        32'd4,       2, '{1'b1, 5'd2, 32'd16, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00051102, 32'd0,        32'h100,      4'b0101, 32'h100,      32'd4,       2, '{1'b1, 5'd2, 32'h10, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h0022183F, 32'd5,        32'd7,        4'b0000, 32'd0,        32'd0,       1, '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1}, 0);
        run(32'h0022182A, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'hFFFFFFFF, 32'd1,       2, '{1'b1, 5'd3, 32'd1, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h3026F0F0, 32'hFFFF00FF, 32'd0,        4'b1001, 32'hFFFF00FF, 32'h0000F0F0, 2, '{1'b1, 5'd6, 32'hF0, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h34268000, 32'd1,        32'd0,        4'b1010, 32'd1,        32'h00008000, 2, '{1'b1, 5'd6, 32'h8001, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00223827, 32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 32'hF0F0F0F0, 32'h0F0F0000, 2, '{1'b1, 5'd7, 32'h00000F0F, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h2826FFFF, 32'hFFFFFFFE, 32'd0,        4'b0111, 32'hFFFFFFFE, 32'hFFFFFFFF, 2, '{1'b1, 5'd6, 32'd1, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00220020, 32'd5,        32'd7,        4'b0000, 32'd5,        32'd7,       2, '{1'b0, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0}, 0);
        run(32'h00221820, 32'd100,      32'd23,       4'b0000, 32'd100,      32'd23,      2, '{1'b1, 5'd3, 32'd123, 1'b0, 1'b0, 1'b0}, 5);

        // Reset in the middle of a mult: result must be dropped
        @(negedge clk);
        instr = 32'h00222818; rs_data = 32'd6; rt_data = 32'd7; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("midrst_op", {28'd0, alu_opselect}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, wb_valid}, 32'd0);
        end
        run(32'h00221820, 32'd1,        32'd2,        4'b0000, 32'd1,        32'd2,       2, '{1'b1, 5'd3, 32'd3, 1'b0, 1'b0, 1'b0}, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
